// File: rtl/scr1_dmem_wait_sram.sv
// Data-memory responder on the SCR1 dmem req/ack/resp protocol.
// A word-organised SRAM window with a programmable number of NOTRDY
// cycles before each response, byte-lane writes, and RDY_ER responses
// for misaligned, out-of-window or malformed requests.

typedef enum logic [1:0] {
  SCR1_MEM_CMD_RD    = 2'b00,
  SCR1_MEM_CMD_WR    = 2'b01,
  SCR1_MEM_CMD_ERROR = 2'b11
} type_scr1_mem_cmd_e;

typedef enum logic [1:0] {
  SCR1_MEM_WIDTH_BYTE  = 2'b00,
  SCR1_MEM_WIDTH_HWORD = 2'b01,
  SCR1_MEM_WIDTH_WORD  = 2'b10,
  SCR1_MEM_WIDTH_ERROR = 2'b11
} type_scr1_mem_width_e;

typedef enum logic [1:0] {
  SCR1_MEM_RESP_NOTRDY = 2'b00,
  SCR1_MEM_RESP_RDY_OK = 2'b01,
  SCR1_MEM_RESP_RDY_ER = 2'b10
} type_scr1_mem_resp_e;

module scr1_dmem_wait_sram #(
  parameter logic [31:0] SCR1_WS_BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned SCR1_WS_SIZE_BYTES  = 4096,
  parameter int unsigned SCR1_WS_WAIT_STATES = 2,
  localparam int unsigned SCR1_DMEM_AWIDTH   = 32,
  localparam int unsigned SCR1_DMEM_DWIDTH   = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          dmem_req_ack,
  input  logic                          dmem_req,
  input  type_scr1_mem_cmd_e            dmem_cmd,
  input  type_scr1_mem_width_e          dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0]   dmem_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   dmem_wdata,
  output logic [SCR1_DMEM_DWIDTH-1:0]   dmem_rdata,
  output type_scr1_mem_resp_e           dmem_resp
);

  localparam int unsigned AW     = $clog2(SCR1_WS_SIZE_BYTES);
  localparam int unsigned IDX_W  = (AW > 2) ? (AW - 2) : 1;
  localparam int unsigned DEPTH  = 1 << IDX_W;
  // With no wait states the access completes on the accepting edge itself,
  // so the live bus fields must be used instead of the latched copy.
  localparam bit          NO_WAIT  = (SCR1_WS_WAIT_STATES == 0);
  localparam logic [3:0]  CNT_INIT = (SCR1_WS_WAIT_STATES > 0) ?
                                     4'(SCR1_WS_WAIT_STATES - 1) : 4'd0;
  localparam logic [31:0] SIZE_W   = 32'(SCR1_WS_SIZE_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Any malformed request is answered with RDY_ER and has no side effect.
  function automatic logic req_error(input type_scr1_mem_cmd_e   c,
                                     input type_scr1_mem_width_e w,
                                     input logic [31:0]          a);
    logic        err;
    logic [31:0] off;
    err = 1'b0;
    off = a - SCR1_WS_BASE_ADDR;
    case (c)
      SCR1_MEM_CMD_RD: err = err;
      SCR1_MEM_CMD_WR: err = err;
      default:         err = 1'b1;
    endcase
    case (w)
      SCR1_MEM_WIDTH_BYTE:  err = err;
      SCR1_MEM_WIDTH_HWORD: err = err | a[0];
      SCR1_MEM_WIDTH_WORD:  err = err | (a[1:0] != 2'b00);
      default:              err = 1'b1;
    endcase
    err = err | (off >= SIZE_W);
    return err;
  endfunction

  // Byte-lane enables for a write at the given byte offset within the word.
  function automatic logic [3:0] lane_be(input type_scr1_mem_width_e w,
                                         input logic [1:0]           a);
    logic [3:0] be;
    case (w)
      SCR1_MEM_WIDTH_BYTE:  be = 4'b0001 << a;
      SCR1_MEM_WIDTH_HWORD: be = 4'b0011 << a;
      SCR1_MEM_WIDTH_WORD:  be = 4'b1111;
      default:              be = 4'b0000;
    endcase
    return be;
  endfunction

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  type_scr1_mem_cmd_e   cmd_q;
  type_scr1_mem_width_e width_q;
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;
  type_scr1_mem_resp_e  resp_q;
  logic [31:0]          mem_q [DEPTH];

  logic                 accept_s;
  logic                 enter_resp_s;
  type_scr1_mem_cmd_e   eff_cmd_s;
  type_scr1_mem_width_e eff_width_s;
  logic [31:0]          eff_addr_s;
  logic [31:0]          eff_wdata_s;
  logic [31:0]          off_s;
  logic [IDX_W-1:0]     idx_s;
  logic                 err_s;
  logic [3:0]           be_s;

  assign dmem_req_ack = (state_q != ST_WAIT);
  assign accept_s     = dmem_req & dmem_req_ack;
  assign dmem_rdata   = rdata_q;
  assign dmem_resp    = resp_q;

  // Select which copy of the request the access stage works on.
  always_comb begin
    eff_cmd_s   = cmd_q;
    eff_width_s = width_q;
    eff_addr_s  = addr_q;
    eff_wdata_s = wdata_q;
    if (NO_WAIT) begin
      eff_cmd_s   = dmem_cmd;
      eff_width_s = dmem_width;
      eff_addr_s  = dmem_addr;
      eff_wdata_s = dmem_wdata;
    end else begin
      eff_cmd_s   = cmd_q;
      eff_width_s = width_q;
      eff_addr_s  = addr_q;
      eff_wdata_s = wdata_q;
    end
  end

  assign off_s = eff_addr_s - SCR1_WS_BASE_ADDR;
  assign idx_s = off_s[IDX_W+1:2];
  assign err_s = req_error(eff_cmd_s, eff_width_s, eff_addr_s);
  assign be_s  = lane_be(eff_width_s, eff_addr_s[1:0]);

  // Next-state logic: wait-state countdown and back-to-back acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept_s) begin
          if (NO_WAIT) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // RESP is only ever reached by a fresh transition, so this marks the access edge.
  assign enter_resp_s = (state_d == ST_RESP);

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request fields on every handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q   <= SCR1_MEM_CMD_RD;
      width_q <= SCR1_MEM_WIDTH_WORD;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (accept_s) begin
      cmd_q   <= dmem_cmd;
      width_q <= dmem_width;
      addr_q  <= dmem_addr;
      wdata_q <= dmem_wdata;
    end
  end

  // Array write; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (enter_resp_s && !err_s && (eff_cmd_s == SCR1_MEM_CMD_WR)) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem_q[idx_s][8*b +: 8] <= eff_wdata_s[8*b +: 8];
        end
      end
    end
  end

  // Response and read word; rdata sees the pre-write word on a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'd0;
      resp_q  <= SCR1_MEM_RESP_NOTRDY;
    end else if (enter_resp_s) begin
      if (err_s) begin
        rdata_q <= 32'd0;
        resp_q  <= SCR1_MEM_RESP_RDY_ER;
      end else begin
        rdata_q <= mem_q[idx_s];
        resp_q  <= SCR1_MEM_RESP_RDY_OK;
      end
    end else begin
      resp_q <= SCR1_MEM_RESP_NOTRDY;
    end
  end

endmodule

// File: tb/tb_scr1_dmem_wait_sram.sv
// Scoreboard bench: two instances (2 wait states and 0 wait states).
// Expected responses are queued at issue time; monitors pop on every
// non-NOTRDY response and check code, data and latency.

module tb_scr1_dmem_wait_sram;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 req2, req0;
  type_scr1_mem_cmd_e   cmd;
  type_scr1_mem_width_e width;
  logic [31:0]          addr, wdata;
  logic                 ack2, ack0;
  logic [31:0]          rdata2, rdata0;
  type_scr1_mem_resp_e  resp2, resp0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    type_scr1_mem_resp_e resp;
    logic [31:0]         rdata;
    bit                  chk;
    int                  acc;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];

  always #5 clk = ~clk;

  // Edge counter used to time responses.
  always @(posedge clk) cyc <= cyc + 1;

  scr1_dmem_wait_sram #(
    .SCR1_WS_BASE_ADDR(32'h0001_0000), .SCR1_WS_SIZE_BYTES(4096), .SCR1_WS_WAIT_STATES(2)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .dmem_req_ack(ack2), .dmem_req(req2),
    .dmem_cmd(cmd), .dmem_width(width), .dmem_addr(addr), .dmem_wdata(wdata),
    .dmem_rdata(rdata2), .dmem_resp(resp2)
  );

  scr1_dmem_wait_sram #(
    .SCR1_WS_BASE_ADDR(32'h0001_0000), .SCR1_WS_SIZE_BYTES(4096), .SCR1_WS_WAIT_STATES(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .dmem_req_ack(ack0), .dmem_req(req0),
    .dmem_cmd(cmd), .dmem_width(width), .dmem_addr(addr), .dmem_wdata(wdata),
    .dmem_rdata(rdata0), .dmem_resp(resp0)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor for the 2-wait-state instance.
  always @(negedge clk) begin
    exp_t e;
    if (resp2 != SCR1_MEM_RESP_NOTRDY) begin
      if (q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ws2_unexpected: got resp %0d expected none", resp2);
      end else begin
        e = q2.pop_front();
        check32("ws2_resp", 32'(resp2), 32'(e.resp));
        if (e.chk) check32("ws2_rdata", rdata2, e.rdata);
        check32("ws2_latency", 32'(cyc), 32'(e.acc + 2));
      end
    end
  end

  // Monitor for the 0-wait-state instance.
  always @(negedge clk) begin
    exp_t e;
    if (resp0 != SCR1_MEM_RESP_NOTRDY) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ws0_unexpected: got resp %0d expected none", resp0);
      end else begin
        e = q0.pop_front();
        check32("ws0_resp", 32'(resp0), 32'(e.resp));
        if (e.chk) check32("ws0_rdata", rdata0, e.rdata);
        check32("ws0_latency", 32'(cyc), 32'(e.acc));
      end
    end
  end

  // Present one request; leaves req high after the accepting edge.
  task automatic issue(input bit s0, input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                       input logic [31:0] a, input logic [31:0] d,
                       input type_scr1_mem_resp_e er, input logic [31:0] ed, input bit chk);
    exp_t e;
    int   guard;
    @(negedge clk);
    cmd = c; width = w; addr = a; wdata = d;
    if (s0) begin
      req0 = 1'b1;
      check32("ws0_ack", 32'(ack0), 32'd1);
    end else begin
      req2  = 1'b1;
      guard = 0;
      while (!ack2 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!ack2) begin
        total++;
        bad++;
        $display("FAIL ws2_ack_timeout: got ack 0 expected 1");
      end
    end
    e.resp  = er;
    e.rdata = ed;
    e.chk   = chk;
    e.acc   = cyc + 1;
    if (s0) q0.push_back(e);
    else    q2.push_back(e);
    @(posedge clk);
  endtask

  // One request on the 2-wait-state instance, then drop req during WAIT.
  task automatic ws2(input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                     input logic [31:0] a, input logic [31:0] d,
                     input type_scr1_mem_resp_e er, input logic [31:0] ed, input bit chk);
    issue(1'b0, c, w, a, d, er, ed, chk);
    @(negedge clk);
    req2 = 1'b0;
  endtask

  localparam type_scr1_mem_cmd_e   RD = SCR1_MEM_CMD_RD;
  localparam type_scr1_mem_cmd_e   WR = SCR1_MEM_CMD_WR;
  localparam type_scr1_mem_width_e B  = SCR1_MEM_WIDTH_BYTE;
  localparam type_scr1_mem_width_e H  = SCR1_MEM_WIDTH_HWORD;
  localparam type_scr1_mem_width_e W  = SCR1_MEM_WIDTH_WORD;
  localparam type_scr1_mem_resp_e  OK = SCR1_MEM_RESP_RDY_OK;
  localparam type_scr1_mem_resp_e  ER = SCR1_MEM_RESP_RDY_ER;

  logic [31:0] b2b_addr [4] = '{32'h0001_0100, 32'h0001_0104, 32'h0001_0108, 32'h0001_010C};
  logic [31:0] b2b_data [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    rst_n = 1'b0;
    req2 = 1'b0; req0 = 1'b0;
    cmd = RD; width = W; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    check32("rst_ack2",   32'(ack2),   32'd1);
    check32("rst_resp2",  32'(resp2),  32'(SCR1_MEM_RESP_NOTRDY));
    check32("rst_rdata2", rdata2,      32'd0);
    check32("rst_ack0",   32'(ack0),   32'd1);
    check32("rst_resp0",  32'(resp0),  32'(SCR1_MEM_RESP_NOTRDY));
    check32("rst_rdata0", rdata0,      32'd0);
    rst_n = 1'b1;

    // Word write/read and byte-lane merge.
    ws2(WR, W, 32'h0001_0010, 32'hDEAD_BEEF, OK, 32'h0, 1'b0);
    ws2(RD, W, 32'h0001_0010, 32'h0,         OK, 32'hDEAD_BEEF, 1'b1);
    ws2(WR, W, 32'h0001_0010, 32'h1122_3344, OK, 32'hDEAD_BEEF, 1'b1);
    ws2(WR, B, 32'h0001_0013, 32'h5500_0000, OK, 32'h1122_3344, 1'b1);
    ws2(RD, W, 32'h0001_0010, 32'h0,         OK, 32'h5522_3344, 1'b1);
    ws2(RD, B, 32'h0001_0011, 32'h0,         OK, 32'h5522_3344, 1'b1);
    // Misalignment leaves the array untouched.
    ws2(WR, W, 32'h0001_0000, 32'hCAFE_F00D, OK, 32'h0, 1'b0);
    ws2(RD, W, 32'h0001_0002, 32'h0,         ER, 32'h0, 1'b1);
    ws2(WR, H, 32'h0001_0001, 32'h0000_FFFF, ER, 32'h0, 1'b1);
    ws2(RD, W, 32'h0001_0000, 32'h0,         OK, 32'hCAFE_F00D, 1'b1);
    // Window boundaries.
    ws2(RD, W, 32'h0001_1000, 32'h0,         ER, 32'h0, 1'b1);
    ws2(RD, W, 32'h0000_FFFC, 32'h0,         ER, 32'h0, 1'b1);
    ws2(WR, W, 32'h0001_0FFC, 32'h1234_5678, OK, 32'h0, 1'b0);
    ws2(RD, W, 32'h0001_0FFC, 32'h0,         OK, 32'h1234_5678, 1'b1);
    // Upper half-word write.
    ws2(WR, W, 32'h0001_0004, 32'h0000_0000, OK, 32'h0, 1'b0);
    ws2(WR, H, 32'h0001_0006, 32'hBEEF_0000, OK, 32'h0, 1'b1);
    // Request held high into RESP: accepted back-to-back.
    issue(1'b0, RD, W, 32'h0001_0004, 32'h0, OK, 32'hBEEF_0000, 1'b1);
    // Malformed command / width.
    ws2(SCR1_MEM_CMD_ERROR, W, 32'h0001_0000, 32'h0, ER, 32'h0, 1'b1);
    ws2(RD, SCR1_MEM_WIDTH_ERROR, 32'h0001_0000, 32'h0, ER, 32'h0, 1'b1);

    // Reset while a write is waiting drops the write.
    ws2(WR, W, 32'h0001_0020, 32'hA5A5_0001, OK, 32'h0, 1'b0);
    repeat (6) @(negedge clk);
    cmd = WR; width = W; addr = 32'h0001_0020; wdata = 32'hFFFF_FFFF;
    req2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req2  = 1'b0;
    rst_n = 1'b0;
    #1;
    check32("abort_resp2",  32'(resp2), 32'(SCR1_MEM_RESP_NOTRDY));
    check32("abort_ack2",   32'(ack2),  32'd1);
    check32("abort_rdata2", rdata2,     32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ws2(RD, W, 32'h0001_0020, 32'h0, OK, 32'hA5A5_0001, 1'b1);
    repeat (6) @(negedge clk);

    // Zero wait states: writes then reads, req held high throughout.
    for (int i = 0; i < 4; i++)
      issue(1'b1, WR, W, b2b_addr[i], b2b_data[i], OK, 32'h0, 1'b0);
    issue(1'b1, RD, W, b2b_addr[3], 32'h0, OK, b2b_data[3], 1'b1);
    for (int i = 0; i < 3; i++)
      issue(1'b1, RD, W, b2b_addr[i], 32'h0, OK, b2b_data[i], 1'b1);
    issue(1'b1, RD, W, 32'h0001_0002, 32'h0, ER, 32'h0, 1'b1);
    @(negedge clk);
    req0 = 1'b0;

    repeat (10) @(negedge clk);
    check32("ws2_pending", 32'(q2.size()), 32'd0);
    check32("ws0_pending", 32'(q0.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
